// File: rtl/collapse_bank_if.sv
// Command/response bundle for collapse_bank: one valid/ready command channel,
// one valid/ready response channel and the armed-cell count.
interface collapse_bank_if #(
  parameter int DATA_W  = 8,
  parameter int BASIS_W = 8,
  parameter int DEPTH   = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [AW-1:0]      cmd_addr;
  logic [DATA_W-1:0]  cmd_data;
  logic [BASIS_W-1:0] cmd_basis;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_hit;
  logic [AW-1:0]      rsp_addr;
  logic [CW-1:0]      armed_count;

  // Host side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_basis, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_addr, armed_count
  );

  // Bank side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_basis, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_addr, armed_count
  );
endinterface

// File: rtl/collapse_bank.sv
// collapse_bank: DEPTH collapse cells. Each cell returns its stored value for up
// to MAX_READS correct-basis reads; any wrong-basis read, exhausted read budget,
// unarmed read or CLEAR replaces the value with LFSR entropy.
module collapse_bank #(
  parameter int          DATA_W    = 8,
  parameter int          BASIS_W   = 8,
  parameter int          DEPTH     = 16,
  parameter int          MAX_READS = 1,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input logic           clk,
  input logic           rst,
  collapse_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(MAX_READS + 1);

  localparam logic [1:0]    OP_INIT   = 2'b00;
  localparam logic [1:0]    OP_READ   = 2'b01;
  localparam logic [1:0]    OP_CLEAR  = 2'b10;
  localparam logic [1:0]    OP_NOP    = 2'b11;
  localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [RW-1:0] MAX_RL    = RW'(MAX_READS);
  localparam logic [CW-1:0] MAX_CNT   = CW'(DEPTH);

  // Right-shift Galois step of the entropy core.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] shifted;
    shifted = {1'b0, s[31:1]};
    if (s[0]) begin
      lfsr_step = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_step = shifted;
    end
  endfunction

  // Storage and registered outputs
  logic [31:0]        lfsr_r;
  logic [DATA_W-1:0]  value_r      [DEPTH];
  logic [BASIS_W-1:0] basis_r      [DEPTH];
  logic               armed_r      [DEPTH];
  logic [RW-1:0]      reads_left_r [DEPTH];
  logic               rsp_valid_r;
  logic [DATA_W-1:0]  rsp_data_r;
  logic               rsp_hit_r;
  logic [AW-1:0]      rsp_addr_r;
  logic [CW-1:0]      armed_count_r;

  // Command decode
  logic               cmd_ready_s;
  logic               accept_s;
  logic               addr_ok_s;
  logic [AW-1:0]      idx_s;
  logic [DATA_W-1:0]  entropy_s;
  logic [DATA_W-1:0]  cur_value_s;
  logic [BASIS_W-1:0] cur_basis_s;
  logic               cur_armed_s;
  logic [RW-1:0]      cur_rl_s;
  logic [DATA_W-1:0]  nxt_value_s;
  logic [BASIS_W-1:0] nxt_basis_s;
  logic               nxt_armed_s;
  logic [RW-1:0]      nxt_rl_s;
  logic               is_read_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic               rd_hit_s;
  logic               arm_inc_s;
  logic               arm_dec_s;

  // A single response buffer: a new command may enter only if the buffer is
  // empty or being drained on this very edge.
  assign cmd_ready_s = !rsp_valid_r || bus.rsp_ready;
  assign accept_s    = bus.cmd_valid && cmd_ready_s;
  assign addr_ok_s   = ({1'b0, bus.cmd_addr} < DEPTH_L);
  assign idx_s       = addr_ok_s ? bus.cmd_addr : {AW{1'b0}};
  assign entropy_s   = lfsr_r[DATA_W-1:0];

  // Out-of-range addresses see an unarmed, non-writable cell.
  assign cur_value_s = value_r[idx_s];
  assign cur_basis_s = basis_r[idx_s];
  assign cur_armed_s = armed_r[idx_s] && addr_ok_s;
  assign cur_rl_s    = reads_left_r[idx_s];

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_hit     = rsp_hit_r;
  assign bus.rsp_addr    = rsp_addr_r;
  assign bus.armed_count = armed_count_r;

  // Next state of the addressed cell and the read result for the current command.
  always_comb begin
    nxt_value_s = cur_value_s;
    nxt_basis_s = cur_basis_s;
    nxt_armed_s = cur_armed_s;
    nxt_rl_s    = cur_rl_s;
    is_read_s   = 1'b0;
    rd_data_s   = entropy_s;
    rd_hit_s    = 1'b0;
    arm_inc_s   = 1'b0;
    arm_dec_s   = 1'b0;
    case (bus.cmd_op)
      OP_INIT: begin
        nxt_value_s = bus.cmd_data;
        nxt_basis_s = bus.cmd_basis;
        nxt_rl_s    = MAX_RL;
        nxt_armed_s = 1'b1;
        arm_inc_s   = !cur_armed_s;
      end
      OP_READ: begin
        is_read_s = 1'b1;
        if (cur_armed_s && (bus.cmd_basis == cur_basis_s)) begin
          rd_data_s = cur_value_s;
          rd_hit_s  = 1'b1;
          if (cur_rl_s <= RW'(1)) begin
            // Last permitted read: the genuine value is handed out once more,
            // then the cell collapses.
            nxt_rl_s    = {RW{1'b0}};
            nxt_armed_s = 1'b0;
            nxt_value_s = entropy_s;
            arm_dec_s   = 1'b1;
          end else begin
            nxt_rl_s = cur_rl_s - RW'(1);
          end
        end else if (cur_armed_s) begin
          // Wrong basis destroys the stored value immediately.
          nxt_armed_s = 1'b0;
          nxt_value_s = entropy_s;
          nxt_rl_s    = {RW{1'b0}};
          arm_dec_s   = 1'b1;
        end else begin
          nxt_value_s = entropy_s;
        end
      end
      OP_CLEAR: begin
        nxt_armed_s = 1'b0;
        nxt_rl_s    = {RW{1'b0}};
        nxt_value_s = entropy_s;
        nxt_basis_s = {BASIS_W{1'b0}};
        arm_dec_s   = cur_armed_s;
      end
      OP_NOP: begin
        nxt_value_s = cur_value_s;
      end
      default: begin
        nxt_value_s = cur_value_s;
      end
    endcase
  end

  // Free-running entropy core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Cell storage: only the addressed cell changes, at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        value_r[i]      <= {DATA_W{1'b0}};
        basis_r[i]      <= {BASIS_W{1'b0}};
        armed_r[i]      <= 1'b0;
        reads_left_r[i] <= {RW{1'b0}};
      end
    end else if (accept_s && addr_ok_s) begin
      value_r[idx_s]      <= nxt_value_s;
      basis_r[idx_s]      <= nxt_basis_s;
      armed_r[idx_s]      <= nxt_armed_s;
      reads_left_r[idx_s] <= nxt_rl_s;
    end
  end

  // Response buffer: loads on READ accept, holds while stalled, empties when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_hit_r   <= 1'b0;
      rsp_addr_r  <= {AW{1'b0}};
    end else if (accept_s && is_read_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= rd_data_s;
      rsp_hit_r   <= rd_hit_s;
      rsp_addr_r  <= bus.cmd_addr;
    end else if (bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Armed-cell population, tracked alongside the cell updates and kept in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_count_r <= {CW{1'b0}};
    end else if (accept_s && addr_ok_s) begin
      if (arm_inc_s && (armed_count_r < MAX_CNT)) begin
        armed_count_r <= armed_count_r + CW'(1);
      end else if (arm_dec_s && (armed_count_r != {CW{1'b0}})) begin
        armed_count_r <= armed_count_r - CW'(1);
      end
    end
  end
endmodule

// File: doc/collapse_bank.md
Name: collapse_bank

Overview:
- Addressable bank of DEPTH Atomic Memory collapse cells behind a single valid/ready command port and a valid/ready response port.
- Each cell holds a value and a basis, and allows up to MAX_READS correct-basis reads before it collapses to entropy.
- The bank contains its own free-running 32-bit LFSR entropy core. It sits between the host command fabric and the cell storage, and is the multi-cell, multi-read successor to the single collapse cell.

Parameters:
DATA_W, 8, width of the stored value (1..32)
BASIS_W, 8, width of the basis tag
DEPTH, 16, number of cells (>=2)
MAX_READS, 1, correct-basis reads allowed before collapse (>=1)
LFSR_SEED, 32'h0000_0001, LFSR reset state (must be nonzero)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at posedge
cmd_op  in  2  00 INIT, 01 READ, 10 CLEAR, 11 NOP (accepted, no effect)
cmd_addr  in  $clog2(DEPTH)  cell index
cmd_data  in  DATA_W  INIT value
cmd_basis  in  BASIS_W  INIT basis / READ measurement basis
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready at posedge
rsp_data  out  DATA_W  read result
rsp_hit  out  1  1 = rsp_data is the genuine stored value
rsp_addr  out  $clog2(DEPTH)  address of the read being answered
armed_count  out  $clog2(DEPTH+1)  number of currently armed cells

Behaviour:
- Reset (async):
  - All cells: value=0, basis=0, armed=0, reads_left=0.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_addr=0, armed_count=0.
  - LFSR state=LFSR_SEED.
  - Reset mid-operation drops any pending response; no command completes.
- LFSR:
  - Right-shift Galois, advances every clk cycle out of reset.
  - next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
  - E = s[DATA_W-1:0], sampled in the cycle of command acceptance.
- Handshake:
  - cmd_ready = !rsp_valid || rsp_ready (combinational), so one response buffer is held at most.
  - Only READ produces a response. rsp_valid asserts the cycle after READ acceptance (latency 1).
  - The rsp_* outputs are held stable while rsp_valid && !rsp_ready.
  - If a response is consumed and a new READ is accepted in the same edge, rsp_valid stays 1 with the new payload.
- Cell state updates at the accept edge. A back-to-back command to the same address sees the updated state.
- INIT, including re-INIT of an armed cell:
  - value=cmd_data, basis=cmd_basis, reads_left=MAX_READS, armed=1.
  - No response.
- READ, armed cell, cmd_basis==basis:
  - rsp_data=value, rsp_hit=1, reads_left-=1.
  - If reads_left becomes 0: armed=0, value=E.
- READ, armed cell, basis mismatch:
  - rsp_data=E, rsp_hit=0.
  - Immediate collapse: armed=0, value=E, reads_left=0.
- READ, unarmed cell: rsp_data=E, rsp_hit=0, value=E.
- CLEAR: armed=0, reads_left=0, value=E, basis=0. No response.
- rsp_addr = cmd_addr of the READ being answered.
- armed_count:
  - Registered and updated at the same edge as the cell state.
  - +1 on INIT of an unarmed cell; −1 on any disarm; unchanged on re-INIT of an armed cell.
- Counters and addresses never wrap beyond their ranges. reads_left saturates at 0.

Test Plan:
1. Reset with LFSR_SEED=1 -> rsp_valid=0, cmd_ready=1, armed_count=0; LFSR reaches 32'h8020_0003 one cycle after reset release.
2. DEPTH=4, MAX_READS=2; INIT addr2 data 0x5A basis 0x3C; READ addr2 basis 0x3C twice -> rsp 0x5A hit=1 both times; armed_count 1 then 0; third READ -> hit=0, data = model E.
3. INIT addr1 data 0xA5 basis 0x11; READ basis 0x12 -> hit=0, data=E; then READ basis 0x11 -> hit=0, data=new E, armed_count=0.
4. READ with rsp_ready=0 for 5 cycles -> cmd_ready=0; rsp_data/hit/addr stable; a pending cmd_valid is not accepted until rsp_ready=1.
5. Continuous READs with rsp_ready=1 -> one response per cycle, in order, addresses match.
6. INIT addr0 and addr3, then assert rst mid-READ -> rsp_valid=0 immediately, armed_count=0; READ addr0 after release -> hit=0.
